cam_cmd_master: RTL and testbench
=================================

# cam_cmd_master

Command initiator for the 32-entry x 32-bit CAM. Accepts read, write and search commands on a valid/ready upstream port and drives the CAM's enable, index and data inputs, one transaction at a time. It captures the CAM's read and search results after a fixed latency and returns them on a valid/ready response port with backpressure. It sits between the control logic, or a bench-side bus, and the CAM's `dut_cam` port group.

## Interface
- `DATA_W`, 32, CAM word width
- `IDX_W`, 5, CAM index width (32 entries)
- `RD_LATENCY`, 1, cycles from the CAM enable cycle to valid CAM outputs; legal range 1..4
- `clk_i`  in  1  clock; all logic on the rising edge
- `rst_i`  in  1  reset; asynchronous assert, active-low
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i` and `cmd_ready_o` are both high
- `cmd_op_i`  in  2  opcode: 00 read, 01 write, 10 search, 11 reserved
- `cmd_index_i`  in  IDX_W  read/write index
- `cmd_data_i`  in  DATA_W  write data or search key
- `rsp_valid_o`  out  1  response present
- `rsp_ready_i`  in  1  response consumed when `rsp_valid_o` and `rsp_ready_i` are both high
- `rsp_op_o`  out  2  opcode echoed from the command
- `rsp_hit_o`  out  1  read valid, or search match
- `rsp_index_o`  out  IDX_W  search match index; read/write index echoed for other ops
- `rsp_data_o`  out  DATA_W  read value; 0 for other ops
- `rsp_err_o`  out  1  reserved opcode was issued
- `cam_read_enable_o`, `cam_write_enable_o`, `cam_search_enable_o`  out  1 each  CAM enables; at most one is high in any cycle
- `cam_read_index_o`, `cam_write_index_o`  out  IDX_W  CAM indices
- `cam_write_data_o`, `cam_search_data_o`  out  DATA_W  CAM data
- `cam_read_valid_i`, `cam_search_valid_i`  in  1  CAM result flags
- `cam_read_value_i`  in  DATA_W  CAM read data
- `cam_search_index_i`  in  IDX_W  CAM match index

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `cmd_ready_o` is high only in this state.
  - On a handshake, the command is latched.
  - Ops 00/01/10 go to ISSUE. Op 11 goes to RESP with `rsp_err_o`=1, `rsp_hit_o`=0, `rsp_data_o`=0, and no CAM activity.
- **ISSUE (exactly 1 cycle):**
  - The enable matching the opcode is high, and its index/data outputs carry the latched values.
  - Read/search go to WAIT.
  - A write goes to RESP if `CAM_CMD_MASTER_WRITE_ACK_EN` is defined, otherwise to IDLE.
- **WAIT (RD_LATENCY cycles):**
  - All enables are low. A down-counter (width 2) is loaded with RD_LATENCY-1.
  - On the final WAIT cycle, the CAM outputs are sampled into the response register:
    - read: `rsp_hit_o` = `cam_read_valid_i`; `rsp_data_o` = `cam_read_value_i` if hit, else 0.
    - search: `rsp_hit_o` = `cam_search_valid_i`; `rsp_index_o` = `cam_search_index_i` if hit, else 0.
  - Then go to RESP.
- **RESP:**
  - `rsp_valid_o` stays high and all `rsp_*` outputs stay stable until `rsp_ready_i`; then go to IDLE.
  - A new command can be accepted at the earliest one cycle after the response handshake.
- Write ack response: `rsp_hit_o`=1, `rsp_index_o` = write index, `rsp_data_o`=0.
- The CAM data/index outputs hold their last driven value while their enable is low.

## Timing
- Reset (async, `rst_i`=0): state IDLE, in-flight command dropped, every output 0, except `cmd_ready_o`, which is 0 during reset and goes to 1 on the first clock edge after release.
- Reset asserted during ISSUE deasserts the CAM enable immediately, without waiting for a clock edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Notation: command handshake at the end of cycle A.
- Read/search:
  - enable high in cycle A+1.
  - CAM outputs sampled at the end of cycle A+1+RD_LATENCY.
  - `rsp_valid_o` high from cycle A+2+RD_LATENCY (A+3 at the default).
- Write: enable in A+1; ack valid in A+2, or `cmd_ready_o` high again in A+2 without ack.
- Reserved op: `rsp_valid_o` high in A+1.
- `rsp_ready_i` held low indefinitely: the response holds and `cmd_ready_o` stays 0. No command is lost or overwritten.

## Configuration
- `CAM_CMD_MASTER_WRITE_ACK_EN`:
  - defined: every write produces a response.
  - undefined: writes are fire-and-forget, and the response port only ever carries read, search and error responses.

## Structure
- Shared package `cam_pkg` holds:
  - `cam_op_e` (READ, WRITE, SEARCH, RSVD)
  - `CAM_DEPTH`=32, `CAM_WIDTH`=32, `CAM_IDX_W`=5
  - `cam_master_state_e`
- Single flat module; no sub-module is warranted.

## Test plan
- Write 0xDEADBEEF to index 7, then read index 7 -> write enable in cycle A+1 with index 7; read response hit=1, data=0xDEADBEEF, `rsp_valid_o` in cycle A+3.
- Write 0x12345678 to index 20, then search 0x12345678 -> response op=10, hit=1, index=20.
- Search 0x0BADF00D against a CAM with no match -> hit=0, index=0, data=0.
- Issue op 11 -> `rsp_valid_o` in cycle A+1, err=1, no CAM enable ever high; a second command is refused until the response is consumed.
- Read with `rsp_ready_i` held low for 10 cycles -> response stable all 10 cycles, `cmd_ready_o`=0, handshake completes in cycle 11, `cmd_ready_o`=1 the following cycle.
- Drop `rst_i` during ISSUE of a write -> `cam_write_enable_o` falls without a clock edge, all outputs 0; after release the first command completes normally.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared types and geometry for the 32 x 32-bit CAM and its
//                command master (opcodes, master FSM states, sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

   localparam int CAM_DEPTH = 32;
   localparam int CAM_WIDTH = 32;
   localparam int CAM_IDX_W = 5;

   // Command / response opcode
   typedef enum logic [1:0] {
      READ   = 2'b00,
      WRITE  = 2'b01,
      SEARCH = 2'b10,
      RSVD   = 2'b11
   } cam_op_e;

   // Command master sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } cam_master_state_e;

endpackage
`default_nettype wire

// File: rtl/cam_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : cam_cmd_master_if
//  Description : Command, response and CAM-side signal bundle of the CAM
//                command master. "master" is the command master's view,
//                "slave" is the view of the upstream controller plus the CAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cam_cmd_master_if #(
   parameter int DATA_W = cam_pkg::CAM_WIDTH,
   parameter int IDX_W  = cam_pkg::CAM_IDX_W
);
   // upstream command port
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [1:0]        cmd_op_i;
   logic [IDX_W-1:0]  cmd_index_i;
   logic [DATA_W-1:0] cmd_data_i;
   // response port
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [1:0]        rsp_op_o;
   logic              rsp_hit_o;
   logic [IDX_W-1:0]  rsp_index_o;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_err_o;
   // CAM port group
   logic              cam_read_enable_o;
   logic              cam_write_enable_o;
   logic              cam_search_enable_o;
   logic [IDX_W-1:0]  cam_read_index_o;
   logic [IDX_W-1:0]  cam_write_index_o;
   logic [DATA_W-1:0] cam_write_data_o;
   logic [DATA_W-1:0] cam_search_data_o;
   logic              cam_read_valid_i;
   logic              cam_search_valid_i;
   logic [DATA_W-1:0] cam_read_value_i;
   logic [IDX_W-1:0]  cam_search_index_i;

   modport master (
      input  cmd_valid_i, cmd_op_i, cmd_index_i, cmd_data_i, rsp_ready_i,
             cam_read_valid_i, cam_search_valid_i, cam_read_value_i, cam_search_index_i,
      output cmd_ready_o, rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_index_o, rsp_data_o,
             rsp_err_o, cam_read_enable_o, cam_write_enable_o, cam_search_enable_o,
             cam_read_index_o, cam_write_index_o, cam_write_data_o, cam_search_data_o
   );

   modport slave (
      output cmd_valid_i, cmd_op_i, cmd_index_i, cmd_data_i, rsp_ready_i,
             cam_read_valid_i, cam_search_valid_i, cam_read_value_i, cam_search_index_i,
      input  cmd_ready_o, rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_index_o, rsp_data_o,
             rsp_err_o, cam_read_enable_o, cam_write_enable_o, cam_search_enable_o,
             cam_read_index_o, cam_write_index_o, cam_write_data_o, cam_search_data_o
   );

endinterface
`default_nettype wire

// File: rtl/cam_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : cam_cmd_master
//  Description : Single-outstanding command initiator for the 32 x 32-bit
//                CAM. Issues read/write/search, captures results after
//                RD_LATENCY cycles and returns them on a valid/ready port.
//                All outputs are registered.
//  Config      : CAM_CMD_MASTER_WRITE_ACK_EN - when defined, every write
//                returns an acknowledge response; otherwise writes are
//                fire-and-forget.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_cmd_master
   import cam_pkg::*;
#(
   parameter int DATA_W     = CAM_WIDTH,
   parameter int IDX_W      = CAM_IDX_W,
   parameter int RD_LATENCY = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   cam_cmd_master_if.master bus
);

   localparam logic [1:0] c_wait_init = 2'(RD_LATENCY - 1);

   cam_master_state_e state_q, state_d;
   cam_op_e           op_q, op_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, sr_en_q, sr_en_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d, sr_data_q, sr_data_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_err_q, rsp_err_d;
   cam_op_e           rsp_op_q, rsp_op_d;
   logic [IDX_W-1:0]  rsp_index_q, rsp_index_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   // Next-state, CAM drive and response capture for the one in-flight command
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      sr_en_d     = 1'b0;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      wr_data_d   = wr_data_q;
      sr_data_d   = sr_data_q;
      rsp_valid_d = rsp_valid_q;
      rsp_op_d    = rsp_op_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_index_d = rsp_index_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i && cmd_ready_q) begin
               op_d  = cam_op_e'(bus.cmd_op_i);
               idx_d = bus.cmd_index_i;
               case (cam_op_e'(bus.cmd_op_i))
                  READ: begin
                     state_d  = ISSUE;
                     rd_en_d  = 1'b1;
                     rd_idx_d = bus.cmd_index_i;
                  end
                  WRITE: begin
                     state_d   = ISSUE;
                     wr_en_d   = 1'b1;
                     wr_idx_d  = bus.cmd_index_i;
                     wr_data_d = bus.cmd_data_i;
                  end
                  SEARCH: begin
                     state_d   = ISSUE;
                     sr_en_d   = 1'b1;
                     sr_data_d = bus.cmd_data_i;
                  end
                  default: begin
                     // Reserved opcode: answer with an error, never touch the CAM
                     state_d     = RESP;
                     rsp_valid_d = 1'b1;
                     rsp_op_d    = RSVD;
                     rsp_hit_d   = 1'b0;
                     rsp_index_d = bus.cmd_index_i;
                     rsp_data_d  = '0;
                     rsp_err_d   = 1'b1;
                  end
               endcase
            end
         end
         ISSUE: begin
            if (op_q == WRITE) begin
`ifdef CAM_CMD_MASTER_WRITE_ACK_EN
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_op_d    = WRITE;
               rsp_hit_d   = 1'b1;
               rsp_index_d = idx_q;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b0;
`else
               state_d     = IDLE;
`endif
            end else begin
               state_d = WAIT;
               cnt_d   = c_wait_init;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_op_d    = op_q;
               rsp_err_d   = 1'b0;
               if (op_q == SEARCH) begin
                  rsp_hit_d   = bus.cam_search_valid_i;
                  rsp_index_d = bus.cam_search_valid_i ? bus.cam_search_index_i : '0;
                  rsp_data_d  = '0;
               end else begin
                  rsp_hit_d   = bus.cam_read_valid_i;
                  rsp_index_d = idx_q;
                  rsp_data_d  = bus.cam_read_valid_i ? bus.cam_read_value_i : '0;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Ready is a flop, so it rises one cycle after returning to IDLE
      cmd_ready_d = (state_d == IDLE);
   end

   // State and output registers; async reset clears every output at once
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         op_q        <= READ;
         idx_q       <= '0;
         cnt_q       <= 2'd0;
         cmd_ready_q <= 1'b0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         sr_en_q     <= 1'b0;
         rd_idx_q    <= '0;
         wr_idx_q    <= '0;
         wr_data_q   <= '0;
         sr_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_op_q    <= READ;
         rsp_hit_q   <= 1'b0;
         rsp_index_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         sr_en_q     <= sr_en_d;
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         wr_data_q   <= wr_data_d;
         sr_data_q   <= sr_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_op_q    <= rsp_op_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_index_q <= rsp_index_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready_o         = cmd_ready_q;
   assign bus.rsp_valid_o         = rsp_valid_q;
   assign bus.rsp_op_o            = rsp_op_q;
   assign bus.rsp_hit_o           = rsp_hit_q;
   assign bus.rsp_index_o         = rsp_index_q;
   assign bus.rsp_data_o          = rsp_data_q;
   assign bus.rsp_err_o           = rsp_err_q;
   assign bus.cam_read_enable_o   = rd_en_q;
   assign bus.cam_write_enable_o  = wr_en_q;
   assign bus.cam_search_enable_o = sr_en_q;
   assign bus.cam_read_index_o    = rd_idx_q;
   assign bus.cam_write_index_o   = wr_idx_q;
   assign bus.cam_write_data_o    = wr_data_q;
   assign bus.cam_search_data_o   = sr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_cmd_master
//  Description : Randomized scoreboard bench for cam_cmd_master with a
//                behavioural CAM and a reference model of expected responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_cmd_master;
   import cam_pkg::*;

   localparam int DATA_W     = 32;
   localparam int IDX_W      = 5;
   localparam int RD_LATENCY = 1;

   typedef struct {
      logic [1:0]  op;
      logic        hit;
      logic [4:0]  idx;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  idx;
      logic [31:0] data;
      int          cyc;
   } iss_t;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   rsp_t exp_q[$];
   iss_t iss_q[$];
   int   rdy_q[$];
   logic [31:0] ref_mem [int];

   int   hold = 0;
   bit   force_next = 0;
   bit   seen = 0;
   bit   rdy_chk_next = 0;
   logic [40:0] held;
   rsp_t cur;
   iss_t it_v;

   logic [31:0] cmem [32];
   bit          cvld [32];
   bit          cam_init = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cam_cmd_master_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   cam_cmd_master #(.DATA_W(DATA_W), .IDX_W(IDX_W), .RD_LATENCY(RD_LATENCY)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   logic any_out;
   assign any_out = |{bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_op_o, bus.rsp_hit_o,
                      bus.rsp_index_o, bus.rsp_data_o, bus.rsp_err_o,
                      bus.cam_read_enable_o, bus.cam_write_enable_o, bus.cam_search_enable_o,
                      bus.cam_read_index_o, bus.cam_write_index_o,
                      bus.cam_write_data_o, bus.cam_search_data_o};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural CAM: one-cycle registered results, lowest index wins a search
   always @(posedge clk) begin
      if (!cam_init) begin
         for (int i = 0; i < 32; i++) begin
            cmem[i] <= $urandom;
            cvld[i] <= 1'b0;
         end
         bus.cam_read_valid_i   <= 1'b0;
         bus.cam_read_value_i   <= '0;
         bus.cam_search_valid_i <= 1'b0;
         bus.cam_search_index_i <= '0;
         cam_init <= 1'b1;
      end else begin
         logic       h;
         logic [4:0] hi;
         h  = 1'b0;
         hi = 5'd0;
         for (int i = 31; i >= 0; i--) begin
            if (cvld[i] && cmem[i] == bus.cam_search_data_o) begin
               h  = 1'b1;
               hi = 5'(i);
            end
         end
         if (bus.cam_write_enable_o) begin
            cmem[bus.cam_write_index_o] <= bus.cam_write_data_o;
            cvld[bus.cam_write_index_o] <= 1'b1;
         end
         bus.cam_read_valid_i   <= bus.cam_read_enable_o && cvld[bus.cam_read_index_o];
         bus.cam_read_value_i   <= cmem[bus.cam_read_index_o];
         bus.cam_search_valid_i <= bus.cam_search_enable_o && h;
         bus.cam_search_index_i <= bus.cam_search_enable_o ? hi : $urandom;
      end
   end

   // CAM-side monitor: each enable must match the next expected issue
   always @(negedge clk) begin
      if (rst_i && (bus.cam_read_enable_o || bus.cam_write_enable_o || bus.cam_search_enable_o)) begin
         chk("en_onehot", $countones({bus.cam_read_enable_o, bus.cam_write_enable_o,
                                      bus.cam_search_enable_o}), 1);
         if (iss_q.size() == 0) begin
            chk("en_unexpected", {bus.cam_read_enable_o, bus.cam_write_enable_o,
                                  bus.cam_search_enable_o}, 0);
         end else begin
            it_v = iss_q.pop_front();
            chk("issue_cycle", cyc, it_v.cyc);
            case (it_v.op)
               2'b00: begin
                  chk("issue_rd_en", bus.cam_read_enable_o, 1);
                  chk("issue_rd_idx", bus.cam_read_index_o, it_v.idx);
               end
               2'b01: begin
                  chk("issue_wr_en", bus.cam_write_enable_o, 1);
                  chk("issue_wr_idx", bus.cam_write_index_o, it_v.idx);
                  chk("issue_wr_data", bus.cam_write_data_o, it_v.data);
               end
               default: begin
                  chk("issue_sr_en", bus.cam_search_enable_o, 1);
                  chk("issue_sr_data", bus.cam_search_data_o, it_v.data);
               end
            endcase
         end
      end
   end

   // Response monitor / scoreboard, also drives rsp_ready_i
   always @(negedge clk) begin
      if (!rst_i) begin
         seen = 0;
         force_next = 0;
         rdy_chk_next = 0;
         exp_q.delete();
         iss_q.delete();
         rdy_q.delete();
         bus.rsp_ready_i = 1'b0;
      end else begin
         if (rdy_chk_next) begin
            chk("rdy_after_rsp", bus.cmd_ready_o, 1);
            rdy_chk_next = 0;
         end
         if (rdy_q.size() != 0 && rdy_q[0] == cyc) begin
            chk("rdy_after_write", bus.cmd_ready_o, 1);
            void'(rdy_q.pop_front());
         end
         if (bus.rsp_valid_o) begin
            chk("rdy_low_in_rsp", bus.cmd_ready_o, 0);
            if (!seen) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", bus.rsp_valid_o, 0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("rsp_cycle", cyc, cur.cyc);
                  chk("rsp_op", bus.rsp_op_o, cur.op);
                  chk("rsp_hit", bus.rsp_hit_o, cur.hit);
                  chk("rsp_index", bus.rsp_index_o, cur.idx);
                  chk("rsp_data", bus.rsp_data_o, cur.data);
                  chk("rsp_err", bus.rsp_err_o, cur.err);
               end
               held = {bus.rsp_op_o, bus.rsp_hit_o, bus.rsp_index_o, bus.rsp_data_o, bus.rsp_err_o};
               seen = 1;
            end else begin
               chk("rsp_stable", {bus.rsp_op_o, bus.rsp_hit_o, bus.rsp_index_o,
                                  bus.rsp_data_o, bus.rsp_err_o}, held);
            end
            if (hold > 0) begin
               bus.rsp_ready_i = 1'b0;
               hold--;
               if (hold == 0) force_next = 1;
            end else if (force_next) begin
               bus.rsp_ready_i = 1'b1;
               force_next = 0;
            end else begin
               bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (bus.rsp_ready_i) begin
               seen = 0;
               rdy_chk_next = 1;
            end
         end else begin
            bus.rsp_ready_i = ($urandom_range(0, 1) == 1);
         end
      end
   end

   // Issue one command; expectations come from the reference memory
   task automatic send(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d,
                       input bit apply);
      int   w, a;
      rsp_t e;
      iss_t s;
      logic hit;
      logic [4:0] fidx;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = op;
      bus.cmd_index_i = idx;
      bus.cmd_data_i  = d;
      w = 0;
      while (!bus.cmd_ready_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!bus.cmd_ready_o) begin
         chk("cmd_accept", bus.cmd_ready_o, 1);
         bus.cmd_valid_i = 1'b0;
         return;
      end
      a = cyc;
      e.op = op; e.err = 1'b0; e.data = '0; e.idx = idx; e.hit = 1'b0;
      e.cyc = a + 2 + RD_LATENCY;
      if (op != 2'b11) begin
         s.op = op; s.idx = idx; s.data = d; s.cyc = a + 1;
         iss_q.push_back(s);
      end
      case (op)
         2'b00: begin
            e.hit  = ref_mem.exists(int'(idx));
            e.data = e.hit ? ref_mem[int'(idx)] : 32'h0;
            exp_q.push_back(e);
         end
         2'b01: begin
            if (apply) ref_mem[int'(idx)] = d;
`ifdef CAM_CMD_MASTER_WRITE_ACK_EN
            e.hit = 1'b1;
            e.cyc = a + 2;
            exp_q.push_back(e);
`else
            rdy_q.push_back(a + 2);
`endif
         end
         2'b10: begin
            hit  = 1'b0;
            fidx = 5'd0;
            foreach (ref_mem[k]) begin
               if (!hit && ref_mem[k] == d) begin
                  hit  = 1'b1;
                  fidx = 5'(k);
               end
            end
            e.hit = hit;
            e.idx = fidx;
            exp_q.push_back(e);
         end
         default: begin
            e.err = 1'b1;
            e.cyc = a + 1;
            exp_q.push_back(e);
         end
      endcase
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = 2'($urandom);
      bus.cmd_index_i = 5'($urandom);
      bus.cmd_data_i  = $urandom;
   endtask

   initial begin
      logic [1:0]  op;
      logic [4:0]  idx;
      logic [31:0] d;
      int          r, w, k;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = 2'b00;
      bus.cmd_index_i = '0;
      bus.cmd_data_i  = '0;
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", any_out, 0);
      rst_i = 1'b1;
      #1 chk("rdy_before_edge", bus.cmd_ready_o, 0);
      @(negedge clk);
      chk("rdy_after_release", bus.cmd_ready_o, 1);

      // Directed scenarios
      send(2'b01, 5'd7, 32'hDEADBEEF, 1);
      send(2'b00, 5'd7, 32'h0, 1);
      send(2'b01, 5'd20, 32'h12345678, 1);
      send(2'b10, 5'd0, 32'h12345678, 1);
      send(2'b10, 5'd3, 32'h0BADF00D, 1);
      hold = 3;
      send(2'b11, 5'd9, 32'h55AA55AA, 1);
      send(2'b00, 5'd20, 32'h0, 1);
      repeat (6) @(negedge clk);
      hold = 10;
      send(2'b00, 5'd7, 32'h0, 1);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         r   = $urandom_range(0, 99);
         idx = 5'($urandom_range(0, 31));
         d   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
         if (r < 35)      op = 2'b01;
         else if (r < 60) op = 2'b00;
         else if (r < 92) op = 2'b10;
         else             op = 2'b11;
         if (op == 2'b10 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 31);
            if (ref_mem.exists(k)) d = ref_mem[k];
         end
         if ($urandom_range(0, 19) == 0) hold = $urandom_range(1, 6);
         send(op, idx, d, 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset during the ISSUE cycle of a write
      w = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid_o) && w < 100) begin
         @(negedge clk);
         w++;
      end
      hold = 0;
      send(2'b01, 5'd9, 32'hA5A5F00D, 0);
      chk("wr_en_in_issue", bus.cam_write_enable_o, 1);
      #2 rst_i = 1'b0;
      #1 chk("async_rst_wr_en", bus.cam_write_enable_o, 0);
      chk("async_rst_outputs", any_out, 0);
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      chk("rdy_after_rerelease", bus.cmd_ready_o, 1);
      send(2'b00, 5'd9, 32'h0, 1);
      send(2'b10, 5'd0, 32'hA5A5F00D, 1);

      // Drain
      w = 0;
      while ((exp_q.size() != 0 || iss_q.size() != 0) && w < 200) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("iss_q_drained", iss_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
